// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NREQ writeback requesters,
// with a software-triggered sweep that writes SWEEP_VAL to x1..x(2^ADDR_W-1).
module regfile_wb_arbiter #(
    parameter int                 NREQ      = 3,
    parameter int                 ADDR_W    = 5,
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  SWEEP_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     sweep_start,
    output logic                     sweep_busy,
    output logic                     sweep_done,
    output logic [7:0]               drop_cnt,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_a3,
    output logic [DATA_W-1:0]        rf_wd
);
    localparam int PTR_W = $clog2(NREQ);

    typedef enum logic {RUN, SWEEP} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_nxt, gsel;
    logic               gfound, accept;
    logic [ADDR_W-1:0]  sweep_cnt, gaddr;
    logic [DATA_W-1:0]  gdata;

    // first valid requester at or after rr_ptr, wrapping
    always_comb begin
        int idx;
        gfound = 1'b0;
        gsel   = '0;
        idx    = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(rr_ptr) + off) % NREQ;
            if (!gfound && req_valid[idx]) begin
                gfound = 1'b1;
                gsel   = PTR_W'(idx);
            end
        end
    end

    assign accept    = gfound && (state == RUN) && !sweep_start && rst;
    assign req_ready = accept ? (NREQ'(1) << gsel) : '0;
    assign gaddr     = req_addr[int'(gsel)*ADDR_W +: ADDR_W];
    assign gdata     = req_data[int'(gsel)*DATA_W +: DATA_W];
    assign rr_nxt    = (gsel == PTR_W'(NREQ-1)) ? '0 : gsel + PTR_W'(1);
    assign sweep_busy = (state == SWEEP);

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (sweep_start) state_nxt = SWEEP;
            SWEEP:   if (sweep_cnt == '1) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= RUN;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr     <= '0;
            sweep_cnt  <= '0;
            rf_we      <= 1'b0;
            rf_a3      <= '0;
            rf_wd      <= '0;
            sweep_done <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            rf_we      <= 1'b0;
            sweep_done <= 1'b0;
            if (state == SWEEP) begin
                rf_we     <= 1'b1;
                rf_a3     <= sweep_cnt;
                rf_wd     <= SWEEP_VAL;
                sweep_cnt <= sweep_cnt + ADDR_W'(1);
                if (sweep_cnt == '1) sweep_done <= 1'b1;
            end else if (sweep_start) begin
                sweep_cnt <= ADDR_W'(1);
            end else if (accept) begin
                rf_a3  <= gaddr;
                rf_wd  <= gdata;
                rf_we  <= (gaddr != '0);
                rr_ptr <= rr_nxt;
                // writes to x0 are accepted but only counted
                if (gaddr == '0 && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: a behavioural model predicts grants and write-port outputs per cycle,
// a negedge monitor compares them against the arbiter.
module tb_regfile_wb_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam logic [DW-1:0] SV = 32'h0;

    logic clk = 1'b0;
    logic rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic sweep_start, sweep_busy, sweep_done, rf_we;
    logic [7:0]    drop_cnt;
    logic [AW-1:0] rf_a3;
    logic [DW-1:0] rf_wd;

    regfile_wb_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .SWEEP_VAL(SV)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .sweep_start(sweep_start),
        .sweep_busy(sweep_busy), .sweep_done(sweep_done), .drop_cnt(drop_cnt),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] a3;
        logic [DW-1:0] wd;
        logic          done;
        logic          busy;
        logic [7:0]    drop;
    } out_t;

    out_t            out_q[$];
    logic [NREQ-1:0] ready_q[$];
    int total = 0;
    int bad   = 0;

    // requester-side pending requests
    logic          pv[NREQ];
    logic [AW-1:0] pa[NREQ];
    logic [DW-1:0] pd[NREQ];
    logic          rstv, startv;
    int            last_g;

    // reference model state
    int            m_rr, m_cnt, m_drop;
    bit            m_sw;
    logic [AW-1:0] m_a3;
    logic [DW-1:0] m_wd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (ready_q.size() > 0) begin
            logic [NREQ-1:0] er;
            er = ready_q.pop_front();
            chk("req_ready", 64'(req_ready), 64'(er));
        end
        if (out_q.size() > 0) begin
            out_t e;
            e = out_q.pop_front();
            chk("rf_we", 64'(rf_we), 64'(e.we));
            chk("rf_a3", 64'(rf_a3), 64'(e.a3));
            chk("rf_wd", 64'(rf_wd), 64'(e.wd));
            chk("sweep_done", 64'(sweep_done), 64'(e.done));
            chk("sweep_busy", 64'(sweep_busy), 64'(e.busy));
            chk("drop_cnt", 64'(drop_cnt), 64'(e.drop));
        end
    end

    // one clock: drive inputs, predict, advance; caller sits just after a posedge
    task automatic step();
        logic [NREQ-1:0] er;
        out_t o;
        rst         = rstv;
        sweep_start = startv;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]           = pv[i];
            req_addr[i*AW +: AW]   = pa[i];
            req_data[i*DW +: DW]   = pd[i];
        end
        er = '0;
        last_g = -1;
        o.we = 1'b0; o.done = 1'b0;
        if (!rstv) begin
            m_rr = 0; m_sw = 0; m_cnt = 0; m_drop = 0; m_a3 = '0; m_wd = '0;
        end else if (m_sw) begin
            o.we = 1'b1; m_a3 = AW'(m_cnt); m_wd = SV;
            if (m_cnt == 31) begin o.done = 1'b1; m_sw = 0; end
            m_cnt = m_cnt + 1;
        end else if (startv) begin
            m_sw = 1; m_cnt = 1;
        end else begin
            for (int off = 0; off < NREQ; off++) begin
                int idx;
                idx = (m_rr + off) % NREQ;
                if (last_g < 0 && pv[idx]) last_g = idx;
            end
            if (last_g >= 0) begin
                er[last_g] = 1'b1;
                m_a3 = pa[last_g]; m_wd = pd[last_g];
                o.we = (pa[last_g] != 0);
                if (pa[last_g] == 0 && m_drop < 255) m_drop++;
                m_rr = (last_g + 1) % NREQ;
            end
        end
        o.a3 = m_a3; o.wd = m_wd; o.busy = m_sw; o.drop = 8'(m_drop);
        ready_q.push_back(er);
        @(posedge clk); #1;
        out_q.push_back(o);
    endtask

    task automatic idle_all();
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
    endtask

    initial begin
        rst = 1'b0; sweep_start = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        rstv = 1'b0; startv = 1'b0;
        for (int i = 0; i < NREQ; i++) begin pv[i] = 1'b0; pa[i] = '0; pd[i] = '0; end
        m_rr = 0; m_sw = 0; m_cnt = 0; m_drop = 0; m_a3 = '0; m_wd = '0;
        @(posedge clk); #1;

        // reset with every requester asking
        for (int i = 0; i < NREQ; i++) begin pv[i] = 1'b1; pa[i] = AW'(i + 3); pd[i] = DW'(i); end
        repeat (2) step();
        rstv = 1'b1;
        idle_all();
        step();

        // single request from requester 1
        pv[1] = 1'b1; pa[1] = 5'd5; pd[1] = 32'hDEADBEEF;
        step();
        idle_all();
        repeat (2) step();

        // round-robin from reset, all held valid
        rstv = 1'b0; step(); rstv = 1'b1;
        for (int i = 0; i < NREQ; i++) begin pv[i] = 1'b1; pa[i] = AW'(10 + i); pd[i] = DW'(32'hA0 + i); end
        repeat (6) step();
        idle_all();
        step();

        // x0 writes saturate the drop counter
        pv[2] = 1'b1; pa[2] = '0; pd[2] = 32'h1234;
        repeat (300) step();
        idle_all();
        step();

        // sweep beats a same-cycle request; restart during sweep ignored
        pv[0] = 1'b1; pa[0] = 5'd7; pd[0] = 32'hCAFE0007;
        startv = 1'b1; step(); startv = 1'b0;
        repeat (5) step();
        startv = 1'b1; step(); startv = 1'b0;
        repeat (28) step();
        idle_all();
        step();

        // reset lands on the x10 sweep write, then a normal request
        startv = 1'b1; step(); startv = 1'b0;
        repeat (9) step();
        rstv = 1'b0; step(); rstv = 1'b1;
        step();
        pv[1] = 1'b1; pa[1] = 5'd9; pd[1] = 32'h55AA55AA;
        step();
        idle_all();
        step();

        // randomized traffic with valid drops, x0 targets and sweeps
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i]) begin
                    if ($urandom_range(2) == 0) begin
                        pv[i] = 1'b1;
                        pa[i] = ($urandom_range(3) == 0) ? '0 : AW'($urandom);
                        pd[i] = $urandom;
                    end
                end else if ($urandom_range(15) == 0) begin
                    pv[i] = 1'b0;
                end
            end
            startv = ($urandom_range(79) == 0);
            rstv   = ($urandom_range(499) != 0);
            step();
            if (last_g >= 0) pv[last_g] = 1'b0;
        end
        startv = 1'b0; rstv = 1'b1; idle_all();
        repeat (2) step();
        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
